// File: rtl/reg16_byte_loader.sv
// Command/feed stage for the 16-bit E/FunSel register: assembles load words from two
// memory bytes and issues one E pulse per command. Define BYTE_LOADER_BIG_ENDIAN_EN for high-byte-first loads.
module reg16_byte_loader #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Cmd,
  input  logic [7:0]  DataIn,
  input  logic        DataValid,
  output logic        DataReady,
  output logic [15:0] I,
  output logic        E,
  output logic [1:0]  FunSel,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  // Handshake: a byte moves in any cycle where DataValid and DataReady are both high;
  // DataReady is high only while waiting for a byte, and DataValid is ignored otherwise.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0]       CMD_LOAD = 2'b10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [1:0]       cmd_q;
  logic [1:0]       funsel_q;
  logic [15:0]      i_q;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic             done_q;
  logic             byte_st;
  logic             xfer;
  logic             tmo_hit;

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_q;
    byte_st   = (state == BYTE0) || (state == BYTE1);
    xfer      = byte_st && DataValid;
    tmo_hit   = byte_st && !DataValid && (tmo_q == TMO_LAST);
    DataReady = byte_st;
    Busy      = (state != IDLE);
    // Reset in the ISSUE cycle must suppress the pulse, so E and Error are gated here.
    E         = (state == ISSUE) && !Reset;
    Error     = tmo_hit && !Reset;
    FunSel    = (state == ISSUE) ? cmd_q : funsel_q;

    case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (Start) state_nxt = (Cmd == CMD_LOAD) ? BYTE0 : ISSUE;
      end
      BYTE0, BYTE1: begin
        if (xfer) begin
          tmo_nxt   = '0;
          state_nxt = (state == BYTE0) ? BYTE1 : ISSUE;
        end else if (tmo_hit) begin
          tmo_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      tmo_q    <= '0;
      cmd_q    <= 2'b00;
      funsel_q <= 2'b00;
      i_q      <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmo_q  <= tmo_nxt;
      done_q <= (state == ISSUE);
      if (state == IDLE && Start) cmd_q <= Cmd;
      if (state == ISSUE) funsel_q <= cmd_q;
      if (xfer) begin
`ifdef BYTE_LOADER_BIG_ENDIAN_EN
        if (state == BYTE0) i_q[15:8] <= DataIn;
        else                i_q[7:0]  <= DataIn;
`else
        if (state == BYTE0) i_q[7:0]  <= DataIn;
        else                i_q[15:8] <= DataIn;
`endif
      end
    end
  end

  assign I    = i_q;
  assign Done = done_q;

endmodule

// File: tb/tb_reg16_byte_loader.sv
// Self-checking bench for reg16_byte_loader: a transaction-level model predicts, per cycle,
// the status pins, E/FunSel and the assembled word from command latencies and byte gaps.
module tb_reg16_byte_loader;

  localparam int TMO = 4;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [1:0]  Cmd;
  logic [7:0]  DataIn;
  logic        DataValid;
  logic        DataReady;
  logic [15:0] I;
  logic        E;
  logic [1:0]  FunSel;
  logic        Busy;
  logic        Done;
  logic        Error;

  int          checks;
  int          errors;
  logic [15:0] m_i;
  logic [1:0]  m_fs;
  logic [15:0] exp_q[$];

  reg16_byte_loader #(.TIMEOUT(TMO), .TMO_W(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Cmd(Cmd),
    .DataIn(DataIn), .DataValid(DataValid), .DataReady(DataReady),
    .I(I), .E(E), .FunSel(FunSel), .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [15:0] put_byte(logic [15:0] w, int idx, logic [7:0] b);
    logic [15:0] r;
    r = w;
`ifdef BYTE_LOADER_BIG_ENDIAN_EN
    if (idx == 0) r[15:8] = b; else r[7:0] = b;
`else
    if (idx == 0) r[7:0] = b; else r[15:8] = b;
`endif
    return r;
  endfunction

  // Cycle 0 is the Start cycle; g0/g1 are the DataValid-low cycles before each byte.
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] b0, input logic [7:0] b1,
                         input int g0, input int g1, input string name);
    int x0, x1, e_c, d_c, err_c, rdy_end, last;
    bit load, in_byte;
    logic [22:0] exp_v, act_v;
    x0 = -1; x1 = -1; e_c = -1; d_c = -1; err_c = -1; rdy_end = -1;
    load = (cmd == 2'b10);
    if (!load) begin
      e_c = 1; d_c = 2; last = 2;
    end else if (g0 >= TMO) begin
      err_c = TMO; rdy_end = err_c; last = err_c;
    end else begin
      x0 = 1 + g0;
      if (g1 >= TMO) begin
        err_c = x0 + TMO; rdy_end = err_c; last = err_c;
      end else begin
        x1 = x0 + 1 + g1; rdy_end = x1; e_c = x1 + 1; d_c = e_c + 1; last = d_c;
      end
    end
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge Clock); #1;
      in_byte   = load && c >= 1 && c <= rdy_end;
      Start     = (c == 0);
      Cmd       = (c == 0) ? cmd : 2'($urandom_range(0, 3));
      DataValid = in_byte ? (c == x0 || c == x1) : 1'($urandom_range(0, 1));
      DataIn    = (c == x0) ? b0 : (c == x1) ? b1 : 8'($urandom_range(0, 255));
      exp_v = {(c >= 1 && c <= last), in_byte, (c == e_c), (c == d_c), (c == err_c),
               ((c == e_c) ? cmd : m_fs), m_i};
      @(negedge Clock);
      act_v = {Busy, DataReady, E, Done, Error, FunSel, I};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: {Busy,Rdy,E,Done,Err,FunSel,I} got %h expected %h",
                 name, c, act_v, exp_v);
      end
      if (c == x0) m_i = put_byte(m_i, 0, b0);
      if (c == x1) m_i = put_byte(m_i, 1, b1);
      if (c == e_c) m_fs = cmd;
    end
    Start = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    logic [22:0] act_v;
    act_v = {Busy, DataReady, E, Done, Error, FunSel, I};
    checks++;
    if (act_v !== 23'h0) begin
      errors++;
      $display("FAIL %s: outputs got %h expected 0", name, act_v);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Cmd = 2'b11; DataValid = 1'b1; DataIn = 8'hA5;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check_idle_zero("reset_held");
    @(posedge Clock); #1;
    Reset = 1'b0; Start = 1'b0; DataValid = 1'b0;
    @(negedge Clock);
    check_idle_zero("reset_released");
    m_i = 16'h0000; m_fs = 2'b00;
  endtask

  task automatic test_clear();
    run_cmd(2'b11, 8'h00, 8'h00, 0, 0, "clear");
  endtask

  task automatic test_load();
    logic [15:0] want;
`ifdef BYTE_LOADER_BIG_ENDIAN_EN
    want = 16'h3412;
`else
    want = 16'h1234;
`endif
    run_cmd(2'b10, 8'h34, 8'h12, 0, 0, "load");
    checks++;
    if (I !== want) begin
      errors++;
      $display("FAIL load_word: I got %h expected %h", I, want);
    end
  endtask

  task automatic test_gap();
    run_cmd(2'b10, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 3, "gap3");
  endtask

  task automatic test_timeout();
    run_cmd(2'b10, 8'h5A, 8'hC3, 0, 1000, "timeout_b1");
    run_cmd(2'b10, 8'h11, 8'h22, 1000, 0, "timeout_b0");
  endtask

  task automatic test_busy_ignore();
    logic [22:0] exp_v, act_v;
    logic [1:0]  fs;
    for (int c = 0; c <= 6; c++) begin
      @(posedge Clock); #1;
      Start     = (c <= 3);
      Cmd       = (c == 0) ? 2'b01 : 2'b11;
      DataValid = 1'($urandom_range(0, 1));
      DataIn    = 8'($urandom_range(0, 255));
      fs = (c == 1) ? 2'b01 : (c == 4) ? 2'b11 : m_fs;
      exp_v = {(c == 1 || c == 2 || c == 4 || c == 5), 1'b0, (c == 1 || c == 4),
               (c == 2 || c == 5), 1'b0, fs, m_i};
      @(negedge Clock);
      act_v = {Busy, DataReady, E, Done, Error, FunSel, I};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d: got %h expected %h", c, act_v, exp_v);
      end
      if (c == 1 || c == 4) m_fs = fs;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Reset in the cycle the second load byte transfers.
    for (int c = 0; c <= 6; c++) begin
      @(posedge Clock); #1;
      Start     = (c == 0);
      Cmd       = 2'b10;
      Reset     = (c == 2);
      DataValid = (c == 1 || c == 2);
      DataIn    = (c == 1) ? 8'h77 : 8'h88;
      @(negedge Clock);
      if (c == 3) check_idle_zero("reset_mid_after");
      else begin
        checks++;
        if (E !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_E cycle %0d: E got %b expected 0", c, E);
        end
      end
    end
    // Reset coinciding with the ISSUE cycle of a clear.
    for (int c = 0; c <= 2; c++) begin
      @(posedge Clock); #1;
      Start = (c == 0); Cmd = 2'b11; Reset = (c == 1); DataValid = 1'b0;
      @(negedge Clock);
      if (c == 1) begin
        checks++;
        if (E !== 1'b0) begin
          errors++;
          $display("FAIL reset_issue_E: E got %b expected 0", E);
        end
      end
      if (c == 2) check_idle_zero("reset_issue_after");
    end
    Start = 1'b0; Reset = 1'b0;
    m_i = 16'h0000; m_fs = 2'b00;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 5), $urandom_range(0, 5), "random");
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_i = 16'h0000; m_fs = 2'b00;
    Reset = 1'b1; Start = 1'b0; Cmd = 2'b00; DataIn = 8'h00; DataValid = 1'b0;
    test_reset();
    test_clear();
    test_load();
    test_gap();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    exp_q.push_back(m_i);
    checks++;
    if (I !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL final_word: I got %h", I);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
